// File: rtl/vrf_bank_arbiter.sv
// Round-robin arbiter sharing one single-port VRF SRAM bank among NumReq requesters.
// Define VRF_ARB_WRITE_PRIO_EN to let valid writes outrank all valid reads.
module vrf_bank_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BeWidth   = 4,
  parameter int unsigned Latency   = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0]                   req_we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]      req_be_i,
  output logic [NumReq-1:0]                   resp_valid_o,
  output logic [DataWidth-1:0]                resp_rdata_o,
  output logic                                sram_req_o,
  output logic                                sram_we_o,
  output logic [AddrWidth-1:0]                sram_addr_o,
  output logic [DataWidth-1:0]                sram_wdata_o,
  output logic [BeWidth-1:0]                  sram_be_o,
  input  logic [DataWidth-1:0]                sram_rdata_i
);

  localparam int unsigned IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
  typedef logic [IdWidth-1:0] id_t;
  typedef logic [IdWidth:0]   sum_t;

  id_t               r_ptr;
  id_t               w_ptr_d;
  logic [NumReq-1:0] w_eligible;
  logic              w_gnt_any;
  id_t               w_gnt_idx;
  sum_t              w_sum;

  logic [Latency-1:0] r_pipe_vld;
  id_t                r_pipe_id [Latency];

  // Nothing is granted while reset is asserted, whatever the requesters drive.
  always_comb begin
    w_eligible = req_valid_i;
`ifdef VRF_ARB_WRITE_PRIO_EN
    if (|(req_valid_i & req_we_i)) begin
      w_eligible = req_valid_i & req_we_i;
    end
`endif
    w_eligible = w_eligible & {NumReq{rst_ni}};
  end

  // First eligible index at or after the pointer, wrapping past NumReq-1.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_sum = {1'b0, r_ptr} + sum_t'(i);
      if (w_sum >= sum_t'(NumReq)) begin
        w_sum = w_sum - sum_t'(NumReq);
      end
      if (!w_gnt_any && w_eligible[w_sum[IdWidth-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_sum[IdWidth-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o  = '0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    w_ptr_d      = r_ptr;
    if (w_gnt_any) begin
      req_ready_o  = NumReq'(1) << w_gnt_idx;
      sram_req_o   = 1'b1;
      sram_we_o    = req_we_i[w_gnt_idx];
      sram_addr_o  = req_addr_i[w_gnt_idx];
      sram_wdata_o = req_wdata_i[w_gnt_idx];
      sram_be_o    = req_be_i[w_gnt_idx];
      w_ptr_d      = (w_gnt_idx == id_t'(NumReq - 1)) ? '0 : w_gnt_idx + id_t'(1);
    end
  end

  // Ids are not reset; only the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr      <= '0;
      r_pipe_vld <= '0;
    end else begin
      r_ptr         <= w_ptr_d;
      r_pipe_vld[0] <= w_gnt_any & ~sram_we_o;
      for (int unsigned s = 1; s < Latency; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
      end
    end
    r_pipe_id[0] <= w_gnt_idx;
    for (int unsigned s = 1; s < Latency; s++) begin
      r_pipe_id[s] <= r_pipe_id[s-1];
    end
  end

  always_comb begin
    resp_valid_o = '0;
    resp_rdata_o = '0;
    if (r_pipe_vld[Latency-1]) begin
      resp_valid_o = NumReq'(1) << r_pipe_id[Latency-1];
      resp_rdata_o = sram_rdata_i;
    end
  end

endmodule

// File: tb/tb_vrf_bank_arbiter.sv
// Directed bench for vrf_bank_arbiter with a byte-enabled SRAM model of read latency Lat.
// Expectations follow VRF_ARB_WRITE_PRIO_EN when the macro is defined.
module tb_vrf_bank_arbiter;

  localparam int unsigned NumReq    = 4;
  localparam int unsigned AddrWidth = 10;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned BeWidth   = 4;
  localparam int unsigned Lat       = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                             rst_n;
  logic [NumReq-1:0]                req_valid;
  logic [NumReq-1:0]                req_ready;
  logic [NumReq-1:0]                req_we;
  logic [NumReq-1:0][AddrWidth-1:0] req_addr;
  logic [NumReq-1:0][DataWidth-1:0] req_wdata;
  logic [NumReq-1:0][BeWidth-1:0]   req_be;
  logic [NumReq-1:0]                resp_valid;
  logic [DataWidth-1:0]             resp_rdata;
  logic                             sram_req;
  logic                             sram_we;
  logic [AddrWidth-1:0]             sram_addr;
  logic [DataWidth-1:0]             sram_wdata;
  logic [BeWidth-1:0]               sram_be;
  logic [DataWidth-1:0]             sram_rdata;

  int n_chk = 0;
  int n_err = 0;

  vrf_bank_arbiter #(
    .NumReq   (NumReq),
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth),
    .BeWidth  (BeWidth),
    .Latency  (Lat)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .resp_valid_o(resp_valid),
    .resp_rdata_o(resp_rdata),
    .sram_req_o  (sram_req),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_be_o   (sram_be),
    .sram_rdata_i(sram_rdata)
  );

  // SRAM model: unwritten words read as 0xA5A50000 | addr.
  logic [31:0] mem [1024];
  logic [1023:0] written = '0;
  logic [31:0] rd_pipe [Lat];

  function automatic logic [31:0] base_word(input logic [9:0] a, input logic w,
                                            input logic [31:0] m);
    return w ? m : (32'hA5A5_0000 | 32'(a));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b+:8] = new_w[8*b+:8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (sram_req && sram_we) begin
      mem[sram_addr]     <= merge(base_word(sram_addr, written[sram_addr], mem[sram_addr]),
                                  sram_wdata, sram_be);
      written[sram_addr] <= 1'b1;
    end
    rd_pipe[0] <= (sram_req && !sram_we) ?
                  base_word(sram_addr, written[sram_addr], mem[sram_addr]) : 32'h0;
    for (int k = 1; k < Lat; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign sram_rdata = rd_pipe[Lat-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr();
    req_valid = '1;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0) begin n_err++;
      $display("FAIL reset_ready: got %h want 0", req_ready); end
    n_chk++; if (sram_req !== 1'b0) begin n_err++;
      $display("FAIL reset_sram_req: got %b want 0", sram_req); end
    tick();
    tick();
    rst_n = 1'b1;
    clr();
    @(negedge clk);
    n_chk++; if (resp_valid !== 4'b0) begin n_err++;
      $display("FAIL reset_resp_valid: got %h want 0", resp_valid); end
    n_chk++; if (resp_rdata !== 32'h0) begin n_err++;
      $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    tick();
  endtask

  // Pointer is 0 on entry; four held readers at 0x10..0x13, 8 grants.
  task automatic test_rr_reads();
    logic [3:0]  exp_gnt;
    logic [9:0]  exp_addr;
    logic [3:0]  exp_resp;
    logic [31:0] exp_data;
    for (int c = 0; c < 8 + int'(Lat); c++) begin
      clr();
      if (c < 8) begin
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) req_addr[k] = 10'(16 + k);
      end
      @(negedge clk);
      exp_gnt  = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      exp_addr = (c < 8) ? 10'(16 + c % 4) : 10'h0;
      exp_resp = 4'h0;
      exp_data = 32'h0;
      if (c >= int'(Lat) && c - int'(Lat) < 8) begin
        exp_resp = 4'(1 << ((c - int'(Lat)) % 4));
        exp_data = 32'hA5A5_0010 + 32'((c - int'(Lat)) % 4);
      end
      n_chk++; if (req_ready !== exp_gnt) begin n_err++;
        $display("FAIL rr_grant c%0d: got %h want %h", c, req_ready, exp_gnt); end
      n_chk++; if (sram_addr !== exp_addr || sram_req !== (c < 8)) begin n_err++;
        $display("FAIL rr_sram c%0d: got req=%b addr=%h want addr %h", c, sram_req, sram_addr,
                 exp_addr); end
      n_chk++; if (resp_valid !== exp_resp || resp_rdata !== exp_data) begin n_err++;
        $display("FAIL rr_resp c%0d: got %h/%h want %h/%h", c, resp_valid, resp_rdata,
                 exp_resp, exp_data); end
      tick();
    end
  endtask

  // Pointer 0 on entry, 3 on exit.
  task automatic test_write_read();
    clr();
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 10'h05;
    req_wdata[2] = 32'hDEADBEEF; req_be[2] = 4'hF;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0100 || sram_we !== 1'b1) begin n_err++;
      $display("FAIL wr_grant: got ready=%h we=%b want 4/1", req_ready, sram_we); end
    n_chk++; if (sram_addr !== 10'h05 || sram_wdata !== 32'hDEADBEEF || sram_be !== 4'hF)
      begin n_err++;
      $display("FAIL wr_fields: got %h %h %h", sram_addr, sram_wdata, sram_be); end
    tick();
    req_we[2] = 1'b0;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0100 || sram_we !== 1'b0 || sram_addr !== 10'h05) begin
      n_err++; $display("FAIL rd_grant: got %h %b %h", req_ready, sram_we, sram_addr); end
    n_chk++; if (resp_valid !== 4'b0) begin n_err++;
      $display("FAIL wr_no_resp: got %h want 0", resp_valid); end
    tick();
    clr();
    for (int j = 0; j < int'(Lat); j++) begin
      @(negedge clk);
      n_chk++;
      if (resp_valid !== ((j == int'(Lat) - 1) ? 4'b0100 : 4'b0) ||
          resp_rdata !== ((j == int'(Lat) - 1) ? 32'hDEADBEEF : 32'h0)) begin
        n_err++; $display("FAIL wr_rd_resp j%0d: got %h/%h", j, resp_valid, resp_rdata); end
      tick();
    end
  endtask

  // Pointer 3 on entry: 3, then wrap to 1, then pointer 2. Exits at 3.
  task automatic test_wrap();
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      clr();
      req_valid = (c < 2) ? 4'b1010 : 4'b1110;
      req_we    = req_valid;
      for (int k = 0; k < 4; k++) req_addr[k] = 10'(32 + k);
      @(negedge clk);
      n_chk++; if (req_ready !== exp_g[c]) begin n_err++;
        $display("FAIL wrap_grant c%0d: got %h want %h", c, req_ready, exp_g[c]); end
      n_chk++; if (resp_valid !== 4'b0) begin n_err++;
        $display("FAIL wrap_no_resp c%0d: got %h", c, resp_valid); end
      tick();
    end
  endtask

  // Pointer 3 on entry; must still be 3 after idling. Exits at 0.
  task automatic test_idle();
    clr();
    req_we = '1;
    for (int k = 0; k < 4; k++) begin req_addr[k] = 10'h3FF; req_wdata[k] = '1; req_be[k] = '1; end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++;
      if (sram_req !== 1'b0 || sram_we !== 1'b0 || sram_addr !== 10'h0 ||
          sram_wdata !== 32'h0 || sram_be !== 4'h0 || req_ready !== 4'h0) begin
        n_err++; $display("FAIL idle c%0d: got req=%b we=%b addr=%h wd=%h be=%h rdy=%h", c,
                          sram_req, sram_we, sram_addr, sram_wdata, sram_be, req_ready); end
      tick();
    end
    req_valid = 4'b1001;
    req_we    = 4'b1001;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b1000) begin n_err++;
      $display("FAIL idle_ptr_hold: got %h want 8", req_ready); end
    tick();
  endtask

  // Pointer 0 on entry, 2 on exit; same-address write then read passes straight through.
  task automatic test_hazard();
    clr();
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 10'h07;
    req_wdata[1] = 32'h12345678; req_be[1] = 4'b0011;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0010 || sram_we !== 1'b1 || sram_be !== 4'b0011) begin
      n_err++; $display("FAIL hz_wr: got %h %b %h", req_ready, sram_we, sram_be); end
    tick();
    req_we[1] = 1'b0;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0010 || sram_we !== 1'b0 || sram_addr !== 10'h07) begin
      n_err++; $display("FAIL hz_rd: got %h %b %h", req_ready, sram_we, sram_addr); end
    tick();
    clr();
    for (int j = 0; j < int'(Lat); j++) begin
      @(negedge clk);
      n_chk++;
      if (resp_valid !== ((j == int'(Lat) - 1) ? 4'b0010 : 4'b0) ||
          resp_rdata !== ((j == int'(Lat) - 1) ? 32'hA5A55678 : 32'h0)) begin
        n_err++; $display("FAIL hz_resp j%0d: got %h/%h", j, resp_valid, resp_rdata); end
      tick();
    end
  endtask

  task automatic test_prio();
    logic [3:0] exp_first, exp_second;
    int         rd_cyc;
`ifdef VRF_ARB_WRITE_PRIO_EN
    exp_first = 4'b1000; exp_second = 4'b0001; rd_cyc = 1;
`else
    exp_first = 4'b0001; exp_second = 4'b1000; rd_cyc = 0;
`endif
    // Pointer 2 on entry: a lone write from 3 moves it to 0.
    clr();
    req_valid = 4'b1000; req_we = 4'b1000; req_addr[3] = 10'h33;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b1000) begin n_err++;
      $display("FAIL prio_setup: got %h want 8", req_ready); end
    tick();
    req_valid = 4'b1001; req_addr[0] = 10'h30;
    @(negedge clk);
    n_chk++; if (req_ready !== exp_first) begin n_err++;
      $display("FAIL prio_first: got %h want %h", req_ready, exp_first); end
    tick();
    req_valid = exp_second;
    @(negedge clk);
    n_chk++; if (req_ready !== exp_second) begin n_err++;
      $display("FAIL prio_second: got %h want %h", req_ready, exp_second); end
    tick();
    clr();
    for (int c = 2; c <= 1 + int'(Lat); c++) begin
      @(negedge clk);
      n_chk++;
      if (resp_valid !== ((c == rd_cyc + int'(Lat)) ? 4'b0001 : 4'b0) ||
          resp_rdata !== ((c == rd_cyc + int'(Lat)) ? 32'hA5A50030 : 32'h0)) begin
        n_err++; $display("FAIL prio_resp c%0d: got %h/%h", c, resp_valid, resp_rdata); end
      tick();
    end
  endtask

  task automatic test_reset_flush();
    clr();
    req_valid = 4'b0001; req_addr[0] = 10'h11;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0001) begin n_err++;
      $display("FAIL flush_grant: got %h want 1", req_ready); end
    tick();
    rst_n = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'h0 || sram_req !== 1'b0) begin n_err++;
      $display("FAIL flush_in_reset: got rdy=%h req=%b want 0", req_ready, sram_req); end
    tick();
    rst_n = 1'b1;
    clr();
    for (int c = 0; c < 2 * int'(Lat) + 2; c++) begin
      @(negedge clk);
      n_chk++; if (resp_valid !== 4'h0 || resp_rdata !== 32'h0) begin n_err++;
        $display("FAIL flush_resp c%0d: got %h/%h want 0", c, resp_valid, resp_rdata); end
      tick();
    end
    req_valid = 4'hF; req_we = 4'hF;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0001) begin n_err++;
      $display("FAIL flush_ptr_zero: got %h want 1", req_ready); end
    tick();
    clr();
  endtask

  initial begin
    test_reset();
    test_rr_reads();
    test_write_read();
    test_wrap();
    test_idle();
    test_hazard();
    test_prio();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
